// File: rtl/sna_request_depacketizer_pkg.sv
// Shared flit format, FIFO sizing and FSM encoding for the SNA request depacketizer.
package sna_request_depacketizer_pkg;

  localparam int unsigned FlitW       = 34;
  localparam int unsigned FifoDepth   = 4;
  localparam int unsigned FifoCntW    = $clog2(FifoDepth + 1);
  localparam int unsigned OnOffThresh = 2;

  // Flit field positions
  localparam int unsigned TypeMsb      = 33;
  localparam int unsigned TypeLsb      = 32;
  localparam int unsigned TailSrcMsb   = 31;
  localparam int unsigned TailSrcLsb   = 24;
  localparam int unsigned TailWriteBit = 8;
  localparam int unsigned TailStrbMsb  = 3;

  typedef enum logic [1:0] {
    FlitBody = 2'b00,
    FlitHead = 2'b01,
    FlitTail = 2'b10
  } flit_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StGetBody,
    StGetTail,
    StAxiReq,
    StWaitResp
  } state_e;

endpackage

// File: rtl/sna_flit_fifo.sv
// Small synchronous FIFO with fall-through read data; writes while full are discarded.
module sna_flit_fifo
  import sna_request_depacketizer_pkg::*;
#(
  parameter int unsigned Width = FlitW,
  parameter int unsigned Depth = FifoDepth
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [Width-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [Width-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_fire, rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_fire = wr_en & ~full;
  assign rd_fire = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(wr_fire) - CntW'(rd_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sna_request_depacketizer.sv
// Reassembles head/body/tail NoC flits into AXI4-Lite write or read requests.
// Optional SNA_PROTO_CHECK_EN adds proto_err and strict packet-format checking.
module sna_request_depacketizer
  import sna_request_depacketizer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FlitW-1:0] noc_data,
  input  logic             is_valid,
  output logic [7:0]       is_on_off,
  output logic [31:0]      awaddr,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wvalid,
  input  logic             wready,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  output logic             req_pending,
  output logic             req_write,
  output logic [7:0]       req_src,
  input  logic             resp_done,
`ifdef SNA_PROTO_CHECK_EN
  output logic             proto_err,
`endif
  output logic             ovf
);

`ifdef SNA_PROTO_CHECK_EN
  localparam bit ProtoCheck = 1'b1;
`else
  localparam bit ProtoCheck = 1'b0;
`endif

  logic [FlitW-1:0]    head_flit;
  logic [1:0]          head_type;
  logic [FifoCntW-1:0] fifo_count;
  logic                fifo_empty, fifo_full, pop, err, tail_write;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  src_q, src_d;
  logic        write_q, write_d, ovf_q;
  logic        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;

  sna_flit_fifo #(
    .Width (FlitW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (is_valid),
    .wr_data (noc_data),
    .rd_en   (pop),
    .rd_data (head_flit),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign head_type = head_flit[TypeMsb:TypeLsb];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    src_d      = src_q;
    write_d    = write_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    ar_pend_d  = ar_pend_q;
    pop        = 1'b0;
    err        = 1'b0;
    tail_write = (state_q == StGetTail);

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_type == FlitHead) begin
            addr_d  = head_flit[31:0];
            state_d = StGetBody;
          end
        end
      end
      StGetBody, StGetTail: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_type)
            FlitHead: begin
              if (ProtoCheck) begin
                err = 1'b1;
              end else begin
                addr_d  = head_flit[31:0];
                state_d = StGetBody;
              end
            end
            FlitBody: begin
              // A repeated body without checking simply replaces the write data
              if (ProtoCheck && state_q == StGetTail) begin
                err = 1'b1;
              end else begin
                wdata_d = head_flit[31:0];
                state_d = StGetTail;
              end
            end
            FlitTail: begin
              if (ProtoCheck && (head_flit[TailWriteBit] != tail_write)) begin
                err = 1'b1;
              end else begin
                src_d     = head_flit[TailSrcMsb:TailSrcLsb];
                write_d   = tail_write;
                if (tail_write) wstrb_d = head_flit[TailStrbMsb:0];
                aw_pend_d = tail_write;
                w_pend_d  = tail_write;
                ar_pend_d = ~tail_write;
                state_d   = StAxiReq;
              end
            end
            default: ;
          endcase
        end
      end
      StAxiReq: begin
        if (write_q) begin
          aw_pend_d = aw_pend_q & ~awready;
          w_pend_d  = w_pend_q & ~wready;
          if (!aw_pend_d && !w_pend_d) state_d = StWaitResp;
        end else begin
          ar_pend_d = ar_pend_q & ~arready;
          if (!ar_pend_d) state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (resp_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (err) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      src_q     <= '0;
      write_q   <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      src_q     <= src_d;
      write_q   <= write_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      ovf_q     <= ovf_q | (is_valid & fifo_full);
    end
  end

`ifdef SNA_PROTO_CHECK_EN
  logic proto_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err_q <= 1'b0;
    else        proto_err_q <= err;
  end
  assign proto_err = proto_err_q;
`endif

  assign is_on_off   = (fifo_count < FifoCntW'(OnOffThresh)) ? 8'hFF : 8'h00;
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign awvalid     = aw_pend_q;
  assign wvalid      = w_pend_q;
  assign arvalid     = ar_pend_q;
  assign req_pending = (state_q == StAxiReq) || (state_q == StWaitResp);
  assign req_write   = write_q;
  assign req_src     = src_q;
  assign ovf         = ovf_q;

endmodule
